// File: rtl/paddle_array_ctrl.sv
// rtl/paddle_array_ctrl.sv - multi-channel paddle Y controller with clamp, recenter and tick-paced motion
// Optional hold-to-accelerate is enabled by defining PADDLE_ACCEL_EN.
module paddle_array_ctrl #(
   parameter int NUM_PADDLES = 2,
   parameter int Y_W         = 10,
   parameter int SCREEN_H    = 480,
   parameter int PAD_H_SMALL = 40,
   parameter int PAD_H_LARGE = 80,
   parameter int STEP        = 4,
   parameter int TICK_DIV    = 200000,
   parameter int ACCEL_TICKS = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       bat_size,
   input  logic                       recenter,
   input  logic [NUM_PADDLES-1:0]     btn_up,
   input  logic [NUM_PADDLES-1:0]     btn_dn,
   input  logic [NUM_PADDLES-1:0]     ai_en,
   input  logic [NUM_PADDLES-1:0]     ai_up,
   input  logic [NUM_PADDLES-1:0]     ai_dn,
   output logic [NUM_PADDLES*Y_W-1:0] pad_y,
   output logic [NUM_PADDLES-1:0]     moving,
   output logic                       tick
);

   localparam int CENTER = (SCREEN_H - PAD_H_LARGE) / 2;
   localparam int CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {DIR_HOLD, DIR_UP, DIR_DN} dir_t;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic [Y_W:0]     limit;

   assign limit = bat_size ? (Y_W+1)'(SCREEN_H - PAD_H_LARGE) : (Y_W+1)'(SCREEN_H - PAD_H_SMALL);

   always_comb begin
      tick_d = (cnt_q == CNT_W'(TICK_DIV - 1));
      cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

   for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_ch
      logic [Y_W-1:0] y_q, y_d;
      logic           mov_q, mov_d;
      logic           up, dn;
      dir_t           dir;
      logic [Y_W:0]   step, y_ext, y_sum, y_new;

      // Auto-player fully replaces the buttons while selected.
      assign up  = ai_en[g] ? ai_up[g] : btn_up[g];
      assign dn  = ai_en[g] ? ai_dn[g] : btn_dn[g];
      assign dir = (up && !dn) ? DIR_UP : ((dn && !up) ? DIR_DN : DIR_HOLD);

`ifdef PADDLE_ACCEL_EN
      localparam int RUN_W = $clog2(ACCEL_TICKS) + 1;
      logic [RUN_W-1:0] run_q, run_d;
      dir_t             last_q, last_d;

      // Step is chosen from the run length before this tick is counted.
      assign step = (run_q >= RUN_W'(ACCEL_TICKS)) ? (Y_W+1)'(2 * STEP) : (Y_W+1)'(STEP);

      always_comb begin
         run_d  = run_q;
         last_d = last_q;
         if (recenter) begin
            run_d  = '0;
            last_d = DIR_HOLD;
         end else if (tick_q) begin
            last_d = dir;
            if (dir != DIR_HOLD && dir == last_q)
               run_d = (run_q == '1) ? run_q : run_q + RUN_W'(1);
            else
               run_d = (dir != DIR_HOLD) ? RUN_W'(1) : '0;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            run_q  <= '0;
            last_q <= DIR_HOLD;
         end else begin
            run_q  <= run_d;
            last_q <= last_d;
         end
      end
`else
      assign step = (Y_W+1)'(STEP);
`endif

      assign y_ext = {1'b0, y_q};
      assign y_sum = y_ext + step;

      always_comb begin
         y_d   = y_q;
         mov_d = mov_q;
         y_new = y_ext;
         case (dir)
            DIR_UP:  y_new = (y_ext >= step) ? y_ext - step : '0;
            DIR_DN:  y_new = (y_sum <= limit) ? y_sum : limit;
            default: y_new = y_ext;
         endcase
         if (recenter) begin
            y_d   = Y_W'(CENTER);
            mov_d = 1'b0;
         end else if (y_ext > limit) begin
            y_d = limit[Y_W-1:0];
         end else if (tick_q) begin
            y_d   = y_new[Y_W-1:0];
            mov_d = (y_new != y_ext);
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            y_q   <= Y_W'(CENTER);
            mov_q <= 1'b0;
         end else begin
            y_q   <= y_d;
            mov_q <= mov_d;
         end
      end

      assign pad_y[g*Y_W +: Y_W] = y_q;
      assign moving[g]           = mov_q;
   end

endmodule
